// File: rtl/tl_pkg.sv
// tl_pkg: shared definitions for the intersection scheduler.
//   - PHASE_W / phase_e : phase codes exposed on the scheduler's phase port
//   - LIGHT_*           : signal head codes
//   - head_light()      : head code for a given phase
package tl_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6
  } phase_e;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_OFF    = 2'b11;

  // ns_head selects which head is being decoded; flash_on selects the
  // lit half of the flash period.
  function automatic logic [1:0] head_light(phase_e ph, logic ns_head, logic flash_on);
    logic [1:0] code;
    code = LIGHT_RED;
    case (ph)
      NS_GREEN:  code = ns_head ? LIGHT_GREEN  : LIGHT_RED;
      NS_YELLOW: code = ns_head ? LIGHT_YELLOW : LIGHT_RED;
      EW_GREEN:  code = ns_head ? LIGHT_RED    : LIGHT_GREEN;
      EW_YELLOW: code = ns_head ? LIGHT_RED    : LIGHT_YELLOW;
      FLASH:     code = flash_on ? LIGHT_YELLOW : LIGHT_OFF;
      default:   code = LIGHT_RED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: elapsed-cycle counter for the current phase.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   en_i          count enable; when low the count holds
//   clr_i         restart from 0 on the next enabled edge
//   limit_i       terminal value for the current phase
//   cnt_o         registered count
//   cnt_nxt_o     value the count takes on the next edge
//   tc_o          count has reached the limit
module phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_comb begin
    cnt_nxt_o = cnt_o;
    if (en_i) begin
      cnt_nxt_o = clr_i ? '0 : cnt_o + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_o <= '0;
    else       cnt_o <= cnt_nxt_o;
  end

  // >= rather than == so that an early-termination limit below the current
  // count still ends the phase immediately.
  assign tc_o = (cnt_o >= limit_i);

endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-road signal sequencer with pedestrian
// requests and night flash mode.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   enable                     0 freezes phase, counter and outputs
//   mode_flash                 level request for flash mode
//   ped_req_ns, ped_req_ew     pedestrian request pulses
//   ns_light, ew_light         head codes (00 red, 01 green, 10 yellow, 11 off)
//   ped_walk_ns, ped_walk_ew   walk indications
//   phase, counter             current phase and cycles elapsed in it
// Build option: PED_CROSSING_EN enables pedestrian latches, walk outputs
// and early green termination. Without it requests are ignored, walks
// stay 0 and greens always run GREEN_T cycles.
module intersection_scheduler
  import tl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int GREEN_T     = 20,
  parameter int MIN_GREEN_T = 8,
  parameter int YELLOW_T    = 4,
  parameter int ALLRED_T    = 2,
  parameter int PED_T       = 10,
  parameter int FLASH_HALF  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode_flash,
  input  logic               ped_req_ns,
  input  logic               ped_req_ew,
  output logic [1:0]         ns_light,
  output logic [1:0]         ew_light,
  output logic               ped_walk_ns,
  output logic               ped_walk_ew,
  output logic [PHASE_W-1:0] phase,
  output logic [CNT_W-1:0]   counter
);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, limit;
  logic             tc, clr;
  logic             req_ns, req_ew;
  logic             latch_ns_q, latch_ew_q;
  logic             enter_ns, enter_ew, flash_on;

`ifdef PED_CROSSING_EN
  assign req_ns = ped_req_ns;
  assign req_ew = ped_req_ew;
`else
  assign req_ns = ped_req_ns & 1'b0;
  assign req_ew = ped_req_ew & 1'b0;
`endif

  // A pending request on the opposite road pulls the green limit down to
  // the minimum green.
  always_comb begin
    limit = '0;
    case (phase_q)
      NS_GREEN:  limit = latch_ew_q ? CNT_W'(MIN_GREEN_T - 1) : CNT_W'(GREEN_T - 1);
      EW_GREEN:  limit = latch_ns_q ? CNT_W'(MIN_GREEN_T - 1) : CNT_W'(GREEN_T - 1);
      NS_YELLOW,
      EW_YELLOW: limit = CNT_W'(YELLOW_T - 1);
      ALLRED_A,
      ALLRED_B:  limit = CNT_W'(ALLRED_T - 1);
      FLASH:     limit = CNT_W'(2 * FLASH_HALF - 1);
      default:   limit = '0;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    if (tc) begin
      case (phase_q)
        NS_GREEN:  phase_d = NS_YELLOW;
        NS_YELLOW: phase_d = ALLRED_A;
        ALLRED_A:  phase_d = mode_flash ? FLASH : EW_GREEN;
        EW_GREEN:  phase_d = EW_YELLOW;
        EW_YELLOW: phase_d = ALLRED_B;
        ALLRED_B:  phase_d = mode_flash ? FLASH : NS_GREEN;
        FLASH:     phase_d = FLASH;
        default:   phase_d = ALLRED_B;
      endcase
    end
    // Leaving flash goes through a full all-red clearance.
    if (phase_q == FLASH && !mode_flash) phase_d = ALLRED_B;
  end

  // In FLASH the terminal count wraps the counter instead of changing phase.
  assign clr      = tc || (phase_d != phase_q);
  assign enter_ns = (phase_d == NS_GREEN) && (phase_q != NS_GREEN);
  assign enter_ew = (phase_d == EW_GREEN) && (phase_q != EW_GREEN);
  assign flash_on = (cnt_nxt < CNT_W'(FLASH_HALF));

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .en_i      (enable),
    .clr_i     (clr),
    .limit_i   (limit),
    .cnt_o     (cnt_q),
    .cnt_nxt_o (cnt_nxt),
    .tc_o      (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q     <= ALLRED_B;
      ns_light    <= LIGHT_RED;
      ew_light    <= LIGHT_RED;
      ped_walk_ns <= 1'b0;
      ped_walk_ew <= 1'b0;
      latch_ns_q  <= 1'b0;
      latch_ew_q  <= 1'b0;
    end else begin
      // Latches keep capturing while frozen; they are consumed only when
      // their own green is actually entered.
      latch_ns_q <= (enable && enter_ns) ? 1'b0 : (latch_ns_q | req_ns);
      latch_ew_q <= (enable && enter_ew) ? 1'b0 : (latch_ew_q | req_ew);
      if (enable) begin
        phase_q     <= phase_d;
        ns_light    <= head_light(phase_d, 1'b1, flash_on);
        ew_light    <= head_light(phase_d, 1'b0, flash_on);
        ped_walk_ns <= (phase_d == NS_GREEN) && (cnt_nxt < CNT_W'(PED_T)) &&
                       (enter_ns ? (latch_ns_q | req_ns) : ped_walk_ns);
        ped_walk_ew <= (phase_d == EW_GREEN) && (cnt_nxt < CNT_W'(PED_T)) &&
                       (enter_ew ? (latch_ew_q | req_ew) : ped_walk_ew);
      end
    end
  end

  assign phase   = phase_q;
  assign counter = cnt_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
module tb_intersection_scheduler;

`ifdef PED_CROSSING_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  localparam logic [2:0] P_NSG = 3'd0, P_NSY = 3'd1, P_ARA = 3'd2, P_EWG = 3'd3,
                         P_EWY = 3'd4, P_ARB = 3'd5, P_FL  = 3'd6;
  localparam logic [1:0] L_RED = 2'b00, L_GRN = 2'b01, L_YEL = 2'b10, L_OFF = 2'b11;

  logic        clk = 1'b0;
  logic        reset, enable, mode_flash, ped_req_ns, ped_req_ew;
  logic [1:0]  ns_light, ew_light;
  logic        ped_walk_ns, ped_walk_ew;
  logic [2:0]  phase;
  logic [31:0] counter;

  int n_checks = 0;
  int n_errors = 0;

  // Normal cycle table: phase, duration, NS head, EW head
  logic [2:0] ph_t [6] = '{P_NSG, P_NSY, P_ARA, P_EWG, P_EWY, P_ARB};
  int         dur_t[6] = '{6, 2, 1, 6, 2, 1};
  logic [1:0] nsl_t[6] = '{L_GRN, L_YEL, L_RED, L_RED, L_RED, L_RED};
  logic [1:0] ewl_t[6] = '{L_RED, L_RED, L_RED, L_GRN, L_YEL, L_RED};

  intersection_scheduler #(
    .CNT_W(32), .GREEN_T(6), .MIN_GREEN_T(3), .YELLOW_T(2),
    .ALLRED_T(1), .PED_T(2), .FLASH_HALF(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode_flash(mode_flash),
    .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .ns_light(ns_light), .ew_light(ew_light),
    .ped_walk_ns(ped_walk_ns), .ped_walk_ew(ped_walk_ew),
    .phase(phase), .counter(counter)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] ph, input int cnt,
                           input logic [1:0] nsl, input logic [1:0] ewl);
    chk({tag, " phase"}, phase, ph);
    chk({tag, " counter"}, counter, cnt);
    chk({tag, " ns_light"}, ns_light, nsl);
    chk({tag, " ew_light"}, ew_light, ewl);
  endtask

  // Bounded wait for a phase; an expired budget shows up as a failed check.
  task automatic wait_phase(input logic [2:0] tgt, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (phase !== tgt && n < max_cyc) begin
      step();
      n++;
    end
    chk({tag, " reached"}, phase, tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; mode_flash = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0;
    step();
    step();
    chk_state("reset", P_ARB, 0, L_RED, L_RED);
    chk("reset walk_ns", ped_walk_ns, 1'b0);
    chk("reset walk_ew", ped_walk_ew, 1'b0);

    // Normal cycle from reset release
    reset = 1'b0;
    step();
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < dur_t[s]; c++) begin
        if (s != 0 || c != 0) step();
        chk_state($sformatf("cycle s%0d c%0d", s, c), ph_t[s], c, nsl_t[s], ewl_t[s]);
      end
    end
    step();
    chk_state("cycle wrap", P_NSG, 0, L_GRN, L_RED);

    // EW request early in NS green: green ends at counter 2
    step();
    ped_req_ew = 1'b1;
    step();
    ped_req_ew = 1'b0;
    chk_state("early ns c2", P_NSG, 2, L_GRN, L_RED);
    step();
    chk("early ns exit", phase, PED ? P_NSY : P_NSG);
    wait_phase(P_EWG, 20, "early ew");
    chk("ew walk c0", ped_walk_ew, PED);
    chk("ew walk c0 ns", ped_walk_ns, 1'b0);
    step();
    chk("ew walk c1", ped_walk_ew, PED);
    step();
    chk("ew walk c2", ped_walk_ew, 1'b0);
    chk("ew green c2", phase, P_EWG);

    // Late EW request: latch visible at counter 4, yellow on the next edge
    wait_phase(P_NSG, 20, "late ns");
    step(); step(); step();
    ped_req_ew = 1'b1;
    step();
    ped_req_ew = 1'b0;
    chk_state("late ns c4", P_NSG, 4, L_GRN, L_RED);
    step();
    chk("late ns exit", phase, PED ? P_NSY : P_NSG);

    // NS request on the entry edge; a request during its own green is
    // held for the next service only
    wait_phase(P_ARB, 30, "entry arb");
    ped_req_ns = 1'b1;
    step();
    ped_req_ns = 1'b0;
    chk_state("entry ns", P_NSG, 0, L_GRN, L_RED);
    chk("entry walk c0", ped_walk_ns, PED);
    step();
    chk("entry walk c1", ped_walk_ns, PED);
    step();
    chk("entry walk c2", ped_walk_ns, 1'b0);
    ped_req_ns = 1'b1;
    step();
    ped_req_ns = 1'b0;
    wait_phase(P_ARB, 30, "own req arb");
    step();
    chk("own req phase", phase, P_NSG);
    chk("own req walk", ped_walk_ns, PED);
    wait_phase(P_ARB, 30, "clear arb");
    step();
    chk("cleared phase", phase, P_NSG);
    chk("cleared walk", ped_walk_ns, 1'b0);

    // Flash requested mid EW green: only taken at ALLRED_B exit
    wait_phase(P_EWG, 20, "flash ewg");
    mode_flash = 1'b1;
    step();
    chk("flash not yet", phase, P_EWG);
    wait_phase(P_ARB, 20, "flash arb");
    for (int k = 0; k < 5; k++) begin
      step();
      chk_state($sformatf("flash k%0d", k), P_FL, k % 4,
                (k % 4 < 2) ? L_YEL : L_OFF, (k % 4 < 2) ? L_YEL : L_OFF);
      if (k == 0) begin
        chk("flash walk_ns", ped_walk_ns, 1'b0);
        chk("flash walk_ew", ped_walk_ew, 1'b0);
      end
    end
    mode_flash = 1'b0;
    step();
    chk_state("flash exit", P_ARB, 0, L_RED, L_RED);
    step();
    chk_state("flash resume", P_NSG, 0, L_GRN, L_RED);

    // Freeze at NS green counter 3
    step(); step(); step();
    chk_state("freeze pre", P_NSG, 3, L_GRN, L_RED);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_state($sformatf("frozen %0d", k), P_NSG, 3, L_GRN, L_RED);
    end
    enable = 1'b1;
    step();
    chk_state("unfrozen", P_NSG, 4, L_GRN, L_RED);

    // Asynchronous reset mid EW yellow
    wait_phase(P_EWY, 40, "rst ewy");
    chk("rst pre ew", ew_light, L_YEL);
    #2;
    reset = 1'b1;
    #1;
    chk_state("async reset", P_ARB, 0, L_RED, L_RED);
    chk("async reset walk_ns", ped_walk_ns, 1'b0);
    chk("async reset walk_ew", ped_walk_ew, 1'b0);
    reset = 1'b0;
    step();
    chk_state("post reset", P_NSG, 0, L_GRN, L_RED);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
